// File: rtl/crc32x64_trailer.sv
// rtl/crc32x64_trailer.sv - buffers crc32x64 words and appends a CRC trailer word per packet
// Define CRC32X64_TRAILER_INVERT_EN to send the bitwise-inverted CRC in the trailer.
module crc32x64_trailer #(
  parameter int FIFO_AW = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             valid_in,
  input  logic             init_in,
  input  logic             eof_in,
  input  logic [63:0]      data_in,
  input  logic [31:0]      crc_in,
  output logic             valid_out,
  output logic             sof_out,
  output logic             eof_out,
  output logic [63:0]      data_out,
  output logic             orphan,
  output logic             overflow,
  output logic [CNT_W-1:0] pkt_count
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int EW    = 98;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic {S_DATA, S_TRAIL} state_t;

  // Entry layout: {sof, eof, crc[31:0], data[63:0]}
  logic [EW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  state_t             state_q, state_d;
  logic               in_pkt_q, in_pkt_d;
  logic               valid_q, valid_d, sof_q, sof_d, eof_q, eof_d;
  logic [63:0]        data_q, data_d;
  logic               orphan_q, orphan_d, overflow_q, overflow_d;
  logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
  logic [31:0]        crc_lat_q, crc_lat_d;
  logic               accept, push, pop;
  logic [EW-1:0]      rd_entry;
  logic [31:0]        trl_crc;

`ifdef CRC32X64_TRAILER_INVERT_EN
  assign trl_crc = ~crc_lat_q;
`else
  assign trl_crc = crc_lat_q;
`endif

  always_comb begin
    rd_entry    = mem_q[rd_ptr_q];
    accept      = valid_in && (init_in || in_pkt_q);
    pop         = ce && (state_q == S_DATA) && (count_q != '0);
    // A pop in the same cycle frees the slot, so a write at full still lands.
    push        = ce && accept && ((count_q != FULL) || pop);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    in_pkt_d    = in_pkt_q;
    valid_d     = valid_q;
    sof_d       = sof_q;
    eof_d       = eof_q;
    data_d      = data_q;
    orphan_d    = orphan_q;
    overflow_d  = overflow_q;
    pkt_count_d = pkt_count_q;
    crc_lat_d   = crc_lat_q;
    if (ce) begin
      orphan_d = valid_in && !accept;
      if (accept) in_pkt_d = !eof_in;
      if (accept && !push) overflow_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push && !pop) count_d = count_q + (FIFO_AW+1)'(1);
      else if (pop && !push) count_d = count_q - (FIFO_AW+1)'(1);
      case (state_q)
        S_DATA: begin
          valid_d = pop;
          sof_d   = pop && rd_entry[97];
          eof_d   = 1'b0;
          if (pop) begin
            data_d = rd_entry[63:0];
            if (rd_entry[96]) begin
              crc_lat_d = rd_entry[95:64];
              state_d   = S_TRAIL;
            end
          end
        end
        S_TRAIL: begin
          valid_d     = 1'b1;
          sof_d       = 1'b0;
          eof_d       = 1'b1;
          data_d      = {32'h0, trl_crc};
          pkt_count_d = pkt_count_q + CNT_W'(1);
          state_d     = S_DATA;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= S_DATA;
      in_pkt_q    <= 1'b0;
      valid_q     <= 1'b0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      data_q      <= '0;
      orphan_q    <= 1'b0;
      overflow_q  <= 1'b0;
      pkt_count_q <= '0;
      crc_lat_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      in_pkt_q    <= in_pkt_d;
      valid_q     <= valid_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      data_q      <= data_d;
      orphan_q    <= orphan_d;
      overflow_q  <= overflow_d;
      pkt_count_q <= pkt_count_d;
      crc_lat_q   <= crc_lat_d;
      if (push) mem_q[wr_ptr_q] <= {init_in, eof_in, crc_in, data_in};
    end
  end

  assign valid_out = valid_q;
  assign sof_out   = sof_q;
  assign eof_out   = eof_q;
  assign data_out  = data_q;
  assign orphan    = orphan_q;
  assign overflow  = overflow_q;
  assign pkt_count = pkt_count_q;
endmodule

// File: tb/tb_crc32x64_trailer.sv
// tb/tb_crc32x64_trailer.sv - directed self-checking bench for crc32x64_trailer
// Expected trailer values follow CRC32X64_TRAILER_INVERT_EN when it is defined.
module tb_crc32x64_trailer;
  logic        clk, rst, ce, valid_in, init_in, eof_in;
  logic [63:0] data_in;
  logic [31:0] crc_in;
  logic        valid_out, sof_out, eof_out, orphan, overflow;
  logic [63:0] data_out;
  logic [31:0] pkt_count;

  typedef struct {
    logic        sof;
    logic        eof;
    logic [63:0] data;
    int          cyc;
  } rec_t;

  rec_t out_q[$];
  int   cyc = 0;
  int   orphan_cnt = 0;
  int   checks = 0;
  int   failures = 0;
  int   in_cyc;
  int   n_eof;
  int   keep [10] = '{0, 1, 2, 3, 4, 5, 6, 7, 9, 11};

  crc32x64_trailer #(.FIFO_AW(2), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .ce(ce), .valid_in(valid_in), .init_in(init_in),
    .eof_in(eof_in), .data_in(data_in), .crc_in(crc_in), .valid_out(valid_out),
    .sof_out(sof_out), .eof_out(eof_out), .data_out(data_out), .orphan(orphan),
    .overflow(overflow), .pkt_count(pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(negedge clk);
      if (valid_out) out_q.push_back('{sof_out, eof_out, data_out, cyc});
      if (orphan) orphan_cnt = orphan_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] exp_trl(input logic [31:0] c);
`ifdef CRC32X64_TRAILER_INVERT_EN
    return {32'h0, ~c};
`else
    return {32'h0, c};
`endif
  endfunction

  task automatic do_reset();
    rst = 1'b1; ce = 1'b1; valid_in = 1'b0; init_in = 1'b0; eof_in = 1'b0;
    data_in = '0; crc_in = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    out_q.delete();
    orphan_cnt = 0;
  endtask

  task automatic send(input logic i, input logic e, input logic [63:0] d, input logic [31:0] c);
    valid_in = 1'b1; init_in = i; eof_in = e; data_in = d; crc_in = c;
    @(posedge clk);
    #1;
    valid_in = 1'b0; init_in = 1'b0; eof_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_rec(input string tag, input int idx, input logic s, input logic e,
                           input logic [63:0] d);
    if (idx < out_q.size()) begin
      check({tag, "_sof"}, 64'(out_q[idx].sof), 64'(s));
      check({tag, "_eof"}, 64'(out_q[idx].eof), 64'(e));
      check({tag, "_data"}, out_q[idx].data, d);
    end else begin
      check({tag, "_missing"}, 64'(out_q.size()), 64'(idx + 1));
    end
  endtask

  initial begin
    // T1: reset state, then a three-word packet
    do_reset();
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_sof", 64'(sof_out), 64'd0);
    check("rst_eof", 64'(eof_out), 64'd0);
    check("rst_data", data_out, 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    check("rst_pkt_count", 64'(pkt_count), 64'd0);
    send(1'b1, 1'b0, 64'd1, 32'h0);
    send(1'b0, 1'b0, 64'd2, 32'h0);
    send(1'b0, 1'b1, 64'd3, 32'hA5A5_0003);
    idle(6);
    check("t1_n", 64'(out_q.size()), 64'd4);
    check_rec("t1_w1", 0, 1'b1, 1'b0, 64'd1);
    check_rec("t1_w2", 1, 1'b0, 1'b0, 64'd2);
    check_rec("t1_w3", 2, 1'b0, 1'b0, 64'd3);
    check_rec("t1_trl", 3, 1'b0, 1'b1, exp_trl(32'hA5A5_0003));
    check("t1_pkt_count", 64'(pkt_count), 64'd1);
    check("t1_idle_valid", 64'(valid_out), 64'd0);

    // T2: one-word packet and latency
    do_reset();
    send(1'b1, 1'b1, 64'h55, 32'h1234);
    in_cyc = cyc;
    idle(5);
    check("t2_n", 64'(out_q.size()), 64'd2);
    check_rec("t2_w", 0, 1'b1, 1'b0, 64'h55);
    check_rec("t2_trl", 1, 1'b0, 1'b1, exp_trl(32'h1234));
    if (out_q.size() >= 2) begin
      check("t2_lat_data", 64'(out_q[0].cyc - in_cyc), 64'd1);
      check("t2_lat_trl", 64'(out_q[1].cyc - in_cyc), 64'd2);
    end
    check("t2_pkt_count", 64'(pkt_count), 64'd1);

    // T3: orphan word then a valid packet
    do_reset();
    send(1'b0, 1'b0, 64'h77, 32'h0);
    idle(3);
    check("t3_orphan_cnt", 64'(orphan_cnt), 64'd1);
    check("t3_no_out", 64'(out_q.size()), 64'd0);
    send(1'b1, 1'b1, 64'h88, 32'hBEEF);
    idle(5);
    check("t3_n", 64'(out_q.size()), 64'd2);
    check_rec("t3_w", 0, 1'b1, 1'b0, 64'h88);
    check_rec("t3_trl", 1, 1'b0, 1'b1, exp_trl(32'hBEEF));
    check("t3_orphan_cnt2", 64'(orphan_cnt), 64'd1);

    // T4: truncated packet followed by a complete one
    do_reset();
    send(1'b1, 1'b0, 64'h10, 32'h0);
    send(1'b0, 1'b0, 64'h11, 32'h0);
    send(1'b1, 1'b0, 64'h20, 32'h0);
    send(1'b0, 1'b1, 64'h21, 32'hC4);
    idle(6);
    check("t4_n", 64'(out_q.size()), 64'd5);
    check_rec("t4_a0", 0, 1'b1, 1'b0, 64'h10);
    check_rec("t4_a1", 1, 1'b0, 1'b0, 64'h11);
    check_rec("t4_b0", 2, 1'b1, 1'b0, 64'h20);
    check_rec("t4_b1", 3, 1'b0, 1'b0, 64'h21);
    check_rec("t4_trl", 4, 1'b0, 1'b1, exp_trl(32'hC4));
    n_eof = 0;
    foreach (out_q[i]) if (out_q[i].eof) n_eof = n_eof + 1;
    check("t4_n_trl", 64'(n_eof), 64'd1);
    check("t4_pkt_count", 64'(pkt_count), 64'd1);

    // T5: 12 back-to-back one-word packets into a 4-entry FIFO; words 8 and 10 drop
    do_reset();
    for (int i = 0; i < 12; i++) send(1'b1, 1'b1, 64'(i), 32'hC000_0000 | 32'(i));
    check("t5_overflow", 64'(overflow), 64'd1);
    idle(14);
    check("t5_n", 64'(out_q.size()), 64'd20);
    for (int k = 0; k < 10; k++) begin
      check_rec($sformatf("t5_w%0d", k), 2 * k, 1'b1, 1'b0, 64'(keep[k]));
      check_rec($sformatf("t5_t%0d", k), 2 * k + 1, 1'b0, 1'b1,
                exp_trl(32'hC000_0000 | 32'(keep[k])));
    end
    check("t5_pkt_count", 64'(pkt_count), 64'd10);
    check("t5_overflow_sticky", 64'(overflow), 64'd1);
    do_reset();
    check("t5_overflow_rst", 64'(overflow), 64'd0);

    // T6: freeze with ce=0 while the trailer is pending
    send(1'b1, 1'b0, 64'd1, 32'h0);
    send(1'b0, 1'b0, 64'd2, 32'h0);
    send(1'b0, 1'b1, 64'd3, 32'hA5A5_0003);
    idle(1);
    check("t6_pre_data", data_out, 64'd3);
    ce = 1'b0;
    for (int k = 0; k < 3; k++) begin
      idle(1);
      check($sformatf("t6_hold_valid%0d", k), 64'(valid_out), 64'd1);
      check($sformatf("t6_hold_eof%0d", k), 64'(eof_out), 64'd0);
      check($sformatf("t6_hold_data%0d", k), data_out, 64'd3);
      check($sformatf("t6_hold_cnt%0d", k), 64'(pkt_count), 64'd0);
    end
    ce = 1'b1;
    idle(1);
    check("t6_trl_eof", 64'(eof_out), 64'd1);
    check("t6_trl_data", data_out, exp_trl(32'hA5A5_0003));
    check("t6_pkt_count", 64'(pkt_count), 64'd1);
    idle(1);
    check("t6_after_valid", 64'(valid_out), 64'd0);
    check("t6_after_data_hold", data_out, exp_trl(32'hA5A5_0003));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
